// File: rtl/fft_dpram_init.sv
`default_nettype none
// ============================================================================
// Module      : fft_dpram_init
// Description : Single-clock dual-port FFT sample RAM with a hardware
//               initialisation engine (zero / index / constant fill),
//               optional bit-reversed addressing on port A, registered reads
//               and port-A-wins write-collision arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_dpram_init #(
  parameter int                   RAM_WIDTH       = 18,
  parameter int                   RAM_ADDR_BITS   = 10,
  parameter int                   RESET_INIT_MODE = 1,
  parameter logic [RAM_WIDTH-1:0] FILL_VALUE      = '0
) (
  input  logic                     ClkA,
  input  logic                     reset,
  input  logic                     init_start,
  input  logic [1:0]               init_mode,
  output logic                     busy,
  output logic                     init_done,
  input  logic [RAM_ADDR_BITS-1:0] addrA,
  input  logic                     bitrevA,
  input  logic [RAM_WIDTH-1:0]     DinA,
  input  logic                     write_enableA,
  output logic [RAM_WIDTH-1:0]     DoutA,
  input  logic [RAM_ADDR_BITS-1:0] addrB,
  input  logic [RAM_WIDTH-1:0]     DinB,
  input  logic                     write_enableB,
  output logic [RAM_WIDTH-1:0]     DoutB,
  output logic                     collision
);

  localparam int                       c_DEPTH      = 2 ** RAM_ADDR_BITS;
  localparam logic [RAM_ADDR_BITS-1:0] c_LAST       = '1;
  localparam logic [RAM_ADDR_BITS-1:0] c_PENULT     = c_LAST - 1'b1;
  localparam logic [1:0]               c_RESET_MODE = 2'(RESET_INIT_MODE);
  localparam logic [1:0]               c_MODE_NONE  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  logic [RAM_WIDTH-1:0]     r_mem [c_DEPTH];
  state_t                   r_state;
  logic [1:0]               r_mode;
  logic [RAM_ADDR_BITS-1:0] r_cnt;
  logic                     r_busy;
  logic                     r_initDone;
  logic                     r_collision;
  logic [RAM_WIDTH-1:0]     r_doutA;
  logic [RAM_WIDTH-1:0]     r_doutB;

  logic [RAM_ADDR_BITS-1:0] w_addrARev;
  logic [RAM_ADDR_BITS-1:0] w_effA;
  logic                     w_sameWrite;
  logic [RAM_WIDTH-1:0]     w_fillIndex;
  logic [RAM_WIDTH-1:0]     w_fillValue;

  // Bit-reversed view of addrA for FFT input reordering
  for (genvar i = 0; i < RAM_ADDR_BITS; i++) begin : g_bitrev
    assign w_addrARev[i] = addrA[RAM_ADDR_BITS-1-i];
  end

  assign w_effA      = bitrevA ? w_addrARev : addrA;
  assign w_sameWrite = write_enableA && write_enableB && (w_effA == addrB);
  // Index fill is the counter zero-extended or truncated to the word width
  assign w_fillIndex = RAM_WIDTH'(r_cnt);

  // Select the word the init engine writes this cycle
  always_comb begin
    w_fillValue = '0;
    case (r_mode)
      2'd1:    w_fillValue = w_fillIndex;
      2'd2:    w_fillValue = FILL_VALUE;
      default: w_fillValue = '0;
    endcase
  end

  // Init engine FSM: IDLE serves both ports, INIT sweeps the array once
  always_ff @(posedge ClkA) begin
    if (reset) begin
      r_cnt      <= '0;
      r_initDone <= 1'b0;
      if (c_RESET_MODE != c_MODE_NONE) begin
        r_state <= ST_INIT;
        r_mode  <= c_RESET_MODE;
        r_busy  <= 1'b1;
      end else begin
        r_state <= ST_IDLE;
        r_mode  <= 2'd0;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_initDone <= 1'b0;
          if (init_start && (init_mode != c_MODE_NONE)) begin
            r_state <= ST_INIT;
            r_mode  <= init_mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_INIT: begin
          if (r_cnt == c_LAST) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_initDone <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            // Pulse lines up with the cycle that writes the last word
            r_initDone <= (r_cnt == c_PENULT);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: init engine owns the array in INIT, port A wins a collision
  always_ff @(posedge ClkA) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_mem[r_cnt] <= w_fillValue;
      end else begin
        if (write_enableA) begin
          r_mem[w_effA] <= DinA;
        end
        if (write_enableB && !w_sameWrite) begin
          r_mem[addrB] <= DinB;
        end
      end
    end
  end

  // Registered read-before-write outputs and collision flag, forced to 0 in INIT
  always_ff @(posedge ClkA) begin
    if (reset || (r_state == ST_INIT)) begin
      r_doutA     <= '0;
      r_doutB     <= '0;
      r_collision <= 1'b0;
    end else begin
      r_doutA     <= r_mem[w_effA];
      r_doutB     <= r_mem[addrB];
      r_collision <= w_sameWrite;
    end
  end

  assign busy      = r_busy;
  assign init_done = r_initDone;
  assign collision = r_collision;
  assign DoutA     = r_doutA;
  assign DoutB     = r_doutB;

endmodule
`default_nettype wire

// File: tb/tb_fft_dpram_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_dpram_init
// Description : Self-checking bench for fft_dpram_init (directed vectors,
//               random port traffic and a behavioural RAM model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_dpram_init;

  localparam int DEPTH = 1024;

  logic        ClkA = 1'b0;
  logic        reset;
  logic        init_start;
  logic [1:0]  init_mode;
  logic        busy;
  logic        init_done;
  logic [9:0]  addrA;
  logic        bitrevA;
  logic [17:0] DinA;
  logic        write_enableA;
  logic [17:0] DoutA;
  logic [9:0]  addrB;
  logic [17:0] DinB;
  logic        write_enableB;
  logic [17:0] DoutB;
  logic        collision;

  always #5 ClkA = ~ClkA;

  fft_dpram_init #(
    .RAM_WIDTH      (18),
    .RAM_ADDR_BITS  (10),
    .RESET_INIT_MODE(1),
    .FILL_VALUE     (18'h2AAAA)
  ) dut (
    .ClkA         (ClkA),
    .reset        (reset),
    .init_start   (init_start),
    .init_mode    (init_mode),
    .busy         (busy),
    .init_done    (init_done),
    .addrA        (addrA),
    .bitrevA      (bitrevA),
    .DinA         (DinA),
    .write_enableA(write_enableA),
    .DoutA        (DoutA),
    .addrB        (addrB),
    .DinB         (DinB),
    .write_enableB(write_enableB),
    .DoutB        (DoutB),
    .collision    (collision)
  );

  int total = 0;
  int bad   = 0;
  int doneSeen = 0;
  int busySeen = 0;

  // Behavioural model: an array plus a count of fill cycles still owed
  logic [17:0] mMem [DEPTH];
  int          mRemain = 0;
  logic [1:0]  mMode   = 2'd0;
  logic [17:0] expDoutA, expDoutB;
  logic        expBusy, expDone, expColl;

  typedef struct {
    logic        weA;
    logic [9:0]  aA;
    logic        rev;
    logic [17:0] dA;
    logic        weB;
    logic [9:0]  aB;
    logic [17:0] dB;
    logic [17:0] eA;
    logic [17:0] eB;
    logic        eC;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [9:0] rev10(input logic [9:0] a);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = a[9-i];
    return r;
  endfunction

  function automatic logic [17:0] fillWord(input logic [1:0] mode, input int idx);
    if (mode == 2'd1) return 18'(idx);
    if (mode == 2'd2) return 18'h2AAAA;
    return 18'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the next edge from the inputs now applied
  task automatic modelStep();
    logic [9:0] ea;
    if (reset) begin
      mRemain = DEPTH; mMode = 2'd1;
      expDoutA = '0; expDoutB = '0; expBusy = 1'b1; expDone = 1'b0; expColl = 1'b0;
    end else if (mRemain > 0) begin
      mRemain--;
      expDoutA = '0; expDoutB = '0; expColl = 1'b0;
      expBusy = (mRemain > 0);
      expDone = (mRemain == 1);
      if (mRemain == 0)
        for (int i = 0; i < DEPTH; i++) mMem[i] = fillWord(mMode, i);
    end else begin
      ea = bitrevA ? rev10(addrA) : addrA;
      expDoutA = mMem[ea];
      expDoutB = mMem[addrB];
      expColl  = write_enableA && write_enableB && (ea == addrB);
      if (write_enableA) mMem[ea] = DinA;
      if (write_enableB && !expColl) mMem[addrB] = DinB;
      expDone = 1'b0;
      if (init_start && init_mode != 2'd3) begin
        mRemain = DEPTH; mMode = init_mode; expBusy = 1'b1;
      end else begin
        expBusy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge ClkA);
    #1;
    check("busy", busy, expBusy);
    check("init_done", init_done, expDone);
    check("collision", collision, expColl);
    check("DoutA", DoutA, expDoutA);
    check("DoutB", DoutB, expDoutB);
    if (init_done) doneSeen++;
    if (busy) busySeen++;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (busy && n < maxCycles) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic readB(input string name, input logic [9:0] a, input logic [17:0] exp);
    addrB = a;
    tick();
    check(name, DoutB, exp);
  endtask

  initial begin
    vecs[0] = '{1'b1, 10'h001, 1'b1, 18'h00123, 1'b0, 10'h001, 18'h0,  18'h2AAAA, 18'h2AAAA, 1'b0};
    vecs[1] = '{1'b0, 10'h001, 1'b0, 18'h0,     1'b0, 10'h200, 18'h0,  18'h2AAAA, 18'h00123, 1'b0};
    vecs[2] = '{1'b1, 10'h010, 1'b0, 18'h11,    1'b1, 10'h010, 18'h22, 18'h2AAAA, 18'h2AAAA, 1'b1};
    vecs[3] = '{1'b0, 10'h010, 1'b0, 18'h0,     1'b0, 10'h010, 18'h0,  18'h11,    18'h11,    1'b0};
    vecs[4] = '{1'b1, 10'h010, 1'b0, 18'h11,    1'b1, 10'h011, 18'h22, 18'h11,    18'h2AAAA, 1'b0};
    vecs[5] = '{1'b0, 10'h011, 1'b0, 18'h0,     1'b0, 10'h010, 18'h0,  18'h22,    18'h11,    1'b0};
    vecs[6] = '{1'b1, 10'h020, 1'b0, 18'h3FFFF, 1'b0, 10'h020, 18'h0,  18'h2AAAA, 18'h2AAAA, 1'b0};
    vecs[7] = '{1'b0, 10'h020, 1'b0, 18'h0,     1'b0, 10'h020, 18'h0,  18'h3FFFF, 18'h3FFFF, 1'b0};
    vecs[8] = '{1'b1, 10'h001, 1'b1, 18'h1,     1'b1, 10'h200, 18'h2,  18'h00123, 18'h00123, 1'b1};
    vecs[9] = '{1'b0, 10'h200, 1'b0, 18'h0,     1'b0, 10'h200, 18'h0,  18'h1,     18'h1,     1'b0};

    reset = 1'b1; init_start = 1'b0; init_mode = 2'd0;
    addrA = '0; bitrevA = 1'b0; DinA = '0; write_enableA = 1'b0;
    addrB = '0; DinB = '0; write_enableB = 1'b0;

    // Power-on fill in index mode
    repeat (2) tick();
    busySeen = 0; doneSeen = 0;
    tick();
    reset = 1'b0;
    waitIdle(1100);
    check("reset_fill_busy_cycles", busySeen, 1024);
    check("reset_fill_done_pulses", doneSeen, 1);
    readB("index_fill_5", 10'h005, 18'd5);
    readB("index_fill_3ff", 10'h3FF, 18'd1023);

    // Constant fill; a second request mid-fill must be ignored
    init_start = 1'b1; init_mode = 2'd2;
    tick();
    init_start = 1'b0;
    check("start_busy", busy, 1);
    doneSeen = 0;
    repeat (100) tick();
    init_start = 1'b1; init_mode = 2'd0;
    tick();
    init_start = 1'b0;
    waitIdle(1100);
    check("const_fill_done_pulses", doneSeen, 1);
    readB("const_fill_0", 10'd0, 18'h2AAAA);
    readB("const_fill_511", 10'd511, 18'h2AAAA);
    readB("const_fill_1023", 10'd1023, 18'h2AAAA);

    // Mode 3 request does nothing
    init_start = 1'b1; init_mode = 2'd3;
    tick();
    init_start = 1'b0;
    check("mode3_ignored", busy, 0);

    // Directed port vectors
    for (int v = 0; v < 10; v++) begin
      write_enableA = vecs[v].weA; addrA = vecs[v].aA; bitrevA = vecs[v].rev; DinA = vecs[v].dA;
      write_enableB = vecs[v].weB; addrB = vecs[v].aB; DinB = vecs[v].dB;
      tick();
      check($sformatf("vec%0d_DoutA", v), DoutA, vecs[v].eA);
      check($sformatf("vec%0d_DoutB", v), DoutB, vecs[v].eB);
      check($sformatf("vec%0d_collision", v), collision, vecs[v].eC);
    end

    // Random traffic over a small window to provoke collisions
    for (int r = 0; r < 400; r++) begin
      write_enableA = 1'($urandom_range(0, 1));
      write_enableB = 1'($urandom_range(0, 1));
      bitrevA       = 1'($urandom_range(0, 1));
      addrA         = 10'($urandom_range(0, 7));
      addrB         = ($urandom_range(0, 1) == 1) ? rev10(10'($urandom_range(0, 7)))
                                                   : 10'($urandom_range(0, 7));
      DinA          = 18'($urandom);
      DinB          = 18'($urandom);
      tick();
    end
    write_enableA = 1'b0; write_enableB = 1'b0; bitrevA = 1'b0;

    // Reset at fill count 500 of a zero fill restarts an index fill
    init_start = 1'b1; init_mode = 2'd0;
    tick();
    init_start = 1'b0;
    repeat (500) tick();
    reset = 1'b1;
    busySeen = 0; doneSeen = 0;
    tick();
    reset = 1'b0;
    waitIdle(1100);
    check("restart_busy_cycles", busySeen, 1024);
    check("restart_done_pulses", doneSeen, 1);
    readB("restart_0", 10'd0, 18'd0);
    readB("restart_250", 10'd250, 18'd250);
    readB("restart_499", 10'd499, 18'd499);
    readB("restart_777", 10'd777, 18'd777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
